// File: rtl/decode_writeback.sv
// decode_writeback
//   SEQ Y86-64 decode / write-back stage. It sits directly after instruction
//   fetch and does four things:
//   - picks the source and destination register IDs from icode, rA and rB;
//   - reads valA and valB from the 15 x 64-bit register file;
//   - writes valE and valM back on the rising clock edge;
//   - holds the processor status FSM (AOK/HLT/ADR/INS) that gates write-back.
//
//   Optional build macro: DECODE_BYPASS_EN
//     defined   : valA/valB forward the value being written in this cycle.
//     undefined : valA/valB show the array contents from before the edge.
//
//   Ports
//     clk, rst                   clock (rising edge), synchronous active-high reset
//     icode, ifun, rA, rB        instruction fields from fetch
//     instr_valid, imem_error,
//     hlt, dmem_error            fault and status flags
//     cnd                        cmovXX condition from execute
//     wb_en                      commit strobe for this cycle
//     valE, valM                 write-back data (ALU result, memory data)
//     srcA, srcB, dstE, dstM     selected register IDs (4'hF = none)
//     valA, valB                 register read data (0 when src is 4'hF)
//     stat, running              processor status; running is 1 while AOK
module decode_writeback #(
    parameter logic [63:0] RSP_INIT = 64'd200,
    parameter int          NREG     = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        instr_valid,
    input  logic        imem_error,
    input  logic        hlt,
    input  logic        dmem_error,
    input  logic        cnd,
    input  logic        wb_en,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [1:0]  stat,
    output logic        running
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    typedef enum logic [1:0] {
        S_AOK = 2'd0,
        S_HLT = 2'd1,
        S_ADR = 2'd2,
        S_INS = 2'd3
    } stat_e;

    stat_e       state, state_nxt;
    logic [63:0] regs [NREG];
    logic        wr_en;
    logic [63:0] rd_a, rd_b;

    // The cmov variant is already resolved into cnd by execute, so ifun
    // carries no information this stage needs.
    logic unused_ifun;
    assign unused_ifun = ^ifun;

    // Register ID selection.
    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (icode)
            4'h2, 4'h4, 4'h6, 4'hA: srcA = rA;
            4'h9, 4'hB:             srcA = RSP;
            default:                srcA = RNONE;
        endcase
        case (icode)
            4'h4, 4'h5, 4'h6:       srcB = rB;
            4'h8, 4'h9, 4'hA, 4'hB: srcB = RSP;
            default:                srcB = RNONE;
        endcase
        case (icode)
            4'h2:                   dstE = cnd ? rB : RNONE;
            4'h3, 4'h6:             dstE = rB;
            4'h8, 4'h9, 4'hA, 4'hB: dstE = RSP;
            default:                dstE = RNONE;
        endcase
        case (icode)
            4'h5, 4'hB:             dstM = rA;
            default:                dstM = RNONE;
        endcase
    end

    // A halting instruction still commits. An address or instruction fault
    // suppresses its own write, and reset aborts whatever is pending.
    assign wr_en = wb_en && (state == S_AOK) && !rst &&
                   !imem_error && instr_valid && !dmem_error;

    // Status FSM
    always_ff @(posedge clk) begin
        if (rst) state <= S_AOK;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == S_AOK) begin
            if (imem_error)       state_nxt = S_ADR;
            else if (!instr_valid) state_nxt = S_INS;
            else if (dmem_error)  state_nxt = S_ADR;
            else if (hlt)         state_nxt = S_HLT;
        end
    end

    assign stat    = state;
    assign running = (state == S_AOK);

    // Register file. dstM is written after dstE so that popq %rsp keeps
    // the popped value (valM) rather than the incremented pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= (i == 4) ? RSP_INIT : 64'd0;
        end else if (wr_en) begin
            if (dstE != RNONE) regs[dstE] <= valE;
            if (dstM != RNONE) regs[dstM] <= valM;
        end
    end

    assign rd_a = (srcA == RNONE) ? 64'd0 : regs[srcA];
    assign rd_b = (srcB == RNONE) ? 64'd0 : regs[srcB];

`ifdef DECODE_BYPASS_EN
    // Write-through. dstM is checked first so that it matches the write
    // priority used by the register file.
    always_comb begin
        valA = rd_a;
        valB = rd_b;
        if (wr_en && dstM != RNONE && srcA == dstM)      valA = valM;
        else if (wr_en && dstE != RNONE && srcA == dstE) valA = valE;
        if (wr_en && dstM != RNONE && srcB == dstM)      valB = valM;
        else if (wr_en && dstE != RNONE && srcB == dstE) valB = valE;
    end
`else
    assign valA = rd_a;
    assign valB = rd_b;
`endif

endmodule
